// File: rtl/mem_xfer_pkg.sv
// Shared types and default sizing for the buffered memory transfer controller.
package mem_xfer_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 64;
    localparam int BURST_LEN_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2
    } xfer_state_t;
endpackage

// File: rtl/mem_xfer_ctrl_if.sv
// Producer, consumer and buffer-memory signals of mem_xfer_ctrl; master is the controller side.
interface mem_xfer_ctrl_if
    import mem_xfer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH_DEF)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  flush;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  burst_done;
    logic                  mem_wen;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;

    modport master (
        input  in_valid, in_data, flush, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, burst_done,
               mem_wen, mem_ren, mem_waddr, mem_raddr, mem_wdata,
               count, full, empty
    );

    modport slave (
        output in_valid, in_data, flush, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, burst_done,
               mem_wen, mem_ren, mem_waddr, mem_raddr, mem_wdata,
               count, full, empty
    );
endinterface

// File: rtl/xfer_ptr_cnt.sv
// Circular buffer bookkeeping: write/read pointers with wrap, occupancy count, full/empty.
module xfer_ptr_cnt
    import mem_xfer_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] wptr,
    output logic [ADDR_WIDTH-1:0] rptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   cnt_nxt,
    output logic                  full,
    output logic                  empty
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    // Explicit wrap so a non-power-of-two DEPTH still works.
    function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign cnt_nxt = count + CW'(wr) - CW'(rd);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge wclk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= inc(wptr);
            if (rd) rptr <= inc(rptr);
            count <= cnt_nxt;
        end
    end
endmodule

// File: rtl/mem_xfer_ctrl.sv
// Buffers a slow producer into an external memory and drains it to a fast consumer in bursts.
module mem_xfer_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BURST_LEN  = BURST_LEN_DEF
) (
    input  logic            wclk,
    input  logic            rst,
    mem_xfer_ctrl_if.master bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int RW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BL_C = CW'(BURST_LEN);

    xfer_state_t           state, state_nxt;
    logic [RW-1:0]         rem, rem_nxt;
    logic                  pend, pend_nxt;
    logic                  wr, rd, last_rd;
    logic                  full, empty;
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [CW-1:0]         count, cnt_nxt;
    logic                  ov_q, done_q;
    logic [DATA_WIDTH-1:0] rdata;

    assign wr      = bus.in_valid && !full;
    assign rd      = (state == ST_BURST) && bus.out_ready && (rem != '0);
    assign last_rd = rd && (rem == RW'(1));

    xfer_ptr_cnt #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ptr (
        .wclk    (wclk),
        .rst     (rst),
        .wr      (wr),
        .rd      (rd),
        .wptr    (wptr),
        .rptr    (rptr),
        .count   (count),
        .cnt_nxt (cnt_nxt),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        pend_nxt  = pend;
        unique case (state)
            ST_IDLE, ST_FILL: begin
                if (cnt_nxt >= BL_C) begin
                    state_nxt = ST_BURST;
                    rem_nxt   = RW'(BURST_LEN);
                end else if (bus.flush && cnt_nxt != '0) begin
                    state_nxt = ST_BURST;
                    rem_nxt   = RW'(cnt_nxt);
                end else begin
                    state_nxt = (cnt_nxt != '0) ? ST_FILL : ST_IDLE;
                end
            end
            ST_BURST: begin
                if (bus.flush) pend_nxt = 1'b1;
                if (last_rd) begin
                    // A full follow-on burst keeps any owed flush for the leftover words.
                    if (cnt_nxt >= BL_C) begin
                        rem_nxt = RW'(BURST_LEN);
                    end else if ((pend || bus.flush) && cnt_nxt != '0) begin
                        rem_nxt  = RW'(cnt_nxt);
                        pend_nxt = 1'b0;
                    end else begin
                        rem_nxt   = '0;
                        pend_nxt  = 1'b0;
                        state_nxt = (cnt_nxt != '0) ? ST_FILL : ST_IDLE;
                    end
                end else if (rd) begin
                    rem_nxt = rem - RW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rem    <= '0;
            pend   <= 1'b0;
            ov_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            pend   <= pend_nxt;
            ov_q   <= rd;
            done_q <= last_rd;
        end
    end

    assign rdata          = bus.mem_rdata;
    assign bus.out_data   = rdata;
    assign bus.out_valid  = ov_q;
    assign bus.burst_done = done_q;
    assign bus.in_ready   = !full;
    assign bus.mem_wen    = wr;
    assign bus.mem_waddr  = wptr;
    assign bus.mem_wdata  = bus.in_data;
    assign bus.mem_ren    = rd;
    assign bus.mem_raddr  = rptr;
    assign bus.count      = count;
    assign bus.full       = full;
    assign bus.empty      = empty;
endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed bench for mem_xfer_ctrl: queue-based reference model plus literal spot checks.
module tb_mem_xfer_ctrl;
    import mem_xfer_pkg::*;

    localparam int DW = 32;
    localparam int DEPTH = 64;
    localparam int AW = 6;
    localparam int BL = 16;

    logic wclk = 1'b0;
    logic rst  = 1'b1;
    always #5 wclk = ~wclk;

    mem_xfer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_xfer_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
        .wclk (wclk),
        .rst  (rst),
        .bus  (bus.master)
    );

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // External buffer memory: registered read data one cycle after mem_ren.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge wclk) begin
        cyc <= cyc + 1;
        if (bus.mem_wen) mem[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr];
    end

    // Reference model: stored words as a queue, burst progress as a word budget.
    logic [DW-1:0] mq[$];
    int rem = 0;
    bit pend = 0;
    bit ev = 0, edn = 0;
    logic [DW-1:0] ed;
    int wtot = 0, rtot = 0;

    function automatic int burst_size(input int n, input bit fl);
        if (n >= BL) return BL;
        if (fl && n > 0) return n;
        return 0;
    endfunction

    always @(posedge wclk) begin
        bit w, r;
        if (rst) begin
            mq.delete(); rem = 0; pend = 0; ev = 0; edn = 0; wtot = 0; rtot = 0;
        end else begin
            w = bus.in_valid && (mq.size() < DEPTH);
            r = (rem > 0) && bus.out_ready;
            ev = r;
            edn = r && (rem == 1);
            if (r) begin ed = mq.pop_front(); rtot++; end
            if (w) begin mq.push_back(bus.in_data); wtot++; end
            if (r && rem == 1) begin
                if (mq.size() >= BL) begin rem = BL; pend = pend || bus.flush; end
                else begin rem = burst_size(mq.size(), pend || bus.flush); pend = 0; end
            end else if (rem > 0) begin
                if (r) rem--;
                if (bus.flush) pend = 1;
            end else begin
                rem = burst_size(mq.size(), bus.flush);
            end
        end
    end

    always @(negedge wclk) begin
        bit pw, pr;
        if (cmp_en) begin
            pw = bus.in_valid && (mq.size() < DEPTH);
            pr = (rem > 0) && bus.out_ready;
            chk("count", bus.count, mq.size());
            chk("full", bus.full, mq.size() == DEPTH);
            chk("empty", bus.empty, mq.size() == 0);
            chk("in_ready", bus.in_ready, mq.size() != DEPTH);
            chk("mem_wen", bus.mem_wen, pw);
            chk("mem_ren", bus.mem_ren, pr);
            if (pw) chk("mem_waddr", bus.mem_waddr, wtot % DEPTH);
            if (pw) chk("mem_wdata", bus.mem_wdata, bus.in_data);
            if (pr) chk("mem_raddr", bus.mem_raddr, rtot % DEPTH);
            chk("out_valid", bus.out_valid, ev);
            chk("burst_done", bus.burst_done, edn);
            if (ev) chk("out_data", bus.out_data, ed);
        end
    end

    // Output log for the literal, hand-computed expectations.
    logic [DW-1:0] olog[$];
    bit dlog[$];
    int clog[$];
    logic [AW-1:0] rlog[$];
    always @(negedge wclk) begin
        if (cmp_en) begin
            if (bus.out_valid) begin
                olog.push_back(bus.out_data); dlog.push_back(bus.burst_done); clog.push_back(cyc);
            end
            if (bus.mem_ren) rlog.push_back(bus.mem_raddr);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge wclk); #1; end
    endtask

    task automatic at_neg();
        @(negedge wclk); #1;
    endtask

    task automatic clr_log();
        olog.delete(); dlog.delete(); clog.delete(); rlog.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int k = 0;
        while (olog.size() < n && k < budget) begin tick(); k++; end
        if (olog.size() < n) chk({nm, "_timeout"}, olog.size(), n);
    endtask

    task automatic stream(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1; bus.in_data = base + DW'(i); tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    endtask

    task automatic chk_seq(input string nm, input logic [DW-1:0] base, input int n);
        chk({nm, "_len"}, olog.size(), n);
        for (int i = 0; i < n && i < olog.size(); i++)
            chk({nm, "_data"}, olog[i], base + DW'(i));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.out_ready = 0;
        rst = 1'b1;
        tick(2);
        cmp_en = 1'b1;
        at_neg();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_state_idle", dut.state == ST_IDLE, 1);
        tick();
        rst = 1'b0;

        // 16 slow writes trigger one full burst.
        clr_log();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.in_valid = 1'b1; bus.in_data = DW'(i); tick();
            bus.in_valid = 1'b0; tick(3);
        end
        wait_log(16, 40, "b16");
        tick(2);
        chk_seq("b16", 32'h1, 16);
        chk("b16_consecutive", clog[15] - clog[0], 15);
        for (int i = 0; i < 16; i++) chk("b16_done", dlog[i], i == 15);
        at_neg();
        chk("b16_count", bus.count, 0);
        chk("b16_idle", dut.state == ST_IDLE, 1);

        // Flush with a short fill.
        tick();
        clr_log();
        stream(32'hA0, 5);
        tick(2);
        pulse_flush();
        wait_log(5, 20, "flush5");
        tick(2);
        chk_seq("flush5", 32'hA0, 5);
        chk("flush5_done4", dlog[4], 1);
        chk("flush5_done3", dlog[3], 0);
        at_neg();
        chk("flush5_count", bus.count, 0);

        // Fill to full with the consumer stalled, then drain four bursts.
        tick();
        clr_log();
        bus.out_ready = 1'b0;
        stream(32'h100, 64);
        bus.in_valid = 1'b1; bus.in_data = 32'h140;
        at_neg();
        chk("full_flag", bus.full, 1);
        chk("full_in_ready", bus.in_ready, 0);
        tick();
        bus.in_valid = 1'b0;
        at_neg();
        chk("full_count", bus.count, 64);
        tick();
        bus.out_ready = 1'b1;
        wait_log(64, 120, "full");
        tick(2);
        chk_seq("full", 32'h100, 64);
        for (int i = 0; i < 64; i++) chk("full_done", dlog[i], (i % 16) == 15);
        chk("full_consecutive", clog[63] - clog[0], 63);

        // Write and read in the same cycle at count 20.
        clr_log();
        bus.out_ready = 1'b0;
        stream(32'h400, 20);
        bus.in_valid = 1'b1; bus.in_data = 32'h414; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        at_neg();
        chk("simul_count20", bus.count, 20);
        tick();
        bus.out_ready = 1'b1;
        wait_log(16, 40, "simul");
        pulse_flush();
        wait_log(21, 40, "simul");
        tick(2);
        chk_seq("simul", 32'h400, 21);
        chk("simul_done15", dlog[15], 1);
        chk("simul_done20", dlog[20], 1);

        // Long stream across pointer wrap with a toggling consumer.
        clr_log();
        begin
            int nxt = 0, c = 0;
            bit acc;
            while (nxt < 130 && c < 2000) begin
                bus.in_valid = 1'b1; bus.in_data = 32'h1000 + DW'(nxt);
                bus.out_ready = ((c / 3) % 2) == 0;
                @(negedge wclk); acc = bus.in_ready;
                tick();
                if (acc) nxt++;
                c++;
            end
            chk("wrap_sent", nxt, 130);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick(2);
        pulse_flush();
        wait_log(130, 400, "wrap");
        tick(2);
        chk_seq("wrap", 32'h1000, 130);

        // Reset in the middle of a burst, then a clean refill.
        clr_log();
        stream(32'h200, 16);
        wait_log(7, 40, "rstmid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_neg();
        chk("rstmid_out_valid", bus.out_valid, 0);
        chk("rstmid_count", bus.count, 0);
        chk("rstmid_empty", bus.empty, 1);
        chk("rstmid_idle", dut.state == ST_IDLE, 1);
        tick();
        clr_log();
        stream(32'h300, 16);
        wait_log(16, 40, "refill");
        tick(2);
        chk_seq("refill", 32'h300, 16);
        chk("refill_raddr0", rlog.size() > 0 ? rlog[0] : 6'h3f, 0);
        chk("refill_done", dlog[15], 1);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_xfer_ctrl.md
MEM_XFER_CTRL -- requirements
Module: mem_xfer_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, word width; DEPTH, 64, buffer entries; ADDR_WIDTH, 6, log2(DEPTH); BURST_LEN, 16, words per outbound burst.
REQ-002 wclk  in  1  single clock for the producer, the consumer and the buffer memory.
REQ-003 rst  in  1  reset, synchronous, active-high, sampled on posedge wclk.
REQ-004 in_valid  in  1  low-rate producer presents in_data.
REQ-005 in_data  in  DATA_WIDTH  producer word.
REQ-006 in_ready  out  1  buffer can accept a word this cycle.
REQ-007 flush  in  1  single-cycle pulse: burst out all stored words even if fewer than BURST_LEN.
REQ-008 out_ready  in  1  high-rate consumer is able to take words.
REQ-009 out_valid  out  1  out_data is valid this cycle.
REQ-010 out_data  out  DATA_WIDTH  word driven directly from mem_rdata.
REQ-011 burst_done  out  1  single-cycle pulse with the last word of a burst.
REQ-012 mem_wen, mem_ren  out  1 each  write and read strobes to the buffer memory.
REQ-013 mem_waddr, mem_raddr  out  ADDR_WIDTH each  buffer addresses.
REQ-014 mem_wdata  out  DATA_WIDTH  equals in_data.
REQ-015 mem_rdata  in  DATA_WIDTH  registered memory output, valid one cycle after mem_ren.
REQ-016 count  out  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
REQ-017 full, empty  out  1 each  count==DEPTH, count==0.

Function
REQ-018 Write handshake: in_ready = !full; a write occurs when in_valid && in_ready, driving mem_wen=1 and mem_waddr=wptr in the same cycle; wptr increments modulo DEPTH.
REQ-019 FSM states: IDLE (count==0), FILL (0<count<BURST_LEN, no flush pending), BURST.
REQ-020 IDLE->FILL on a write; FILL->BURST when count reaches BURST_LEN or on flush; IDLE with flush stays IDLE and produces no burst.
REQ-021 Entering BURST latches burst_rem = min(count, BURST_LEN) (min(count, BURST_LEN) in the flush case too), using count after any same-cycle write.
REQ-022 In BURST: mem_ren=1 and mem_raddr=rptr in every cycle with out_ready=1 and burst_rem>0; rptr increments modulo DEPTH and burst_rem decrements on each such cycle; with out_ready=0 there is no read and the burst pauses.
REQ-023 out_valid is mem_ren delayed by exactly one cycle; out_data=mem_rdata; the consumer accepts every out_valid word unconditionally.
REQ-024 burst_done is asserted together with out_valid for the word read when burst_rem went 1->0.
REQ-025 Burst end: at the cycle the last read is issued, go to BURST again if the remaining count>=BURST_LEN, else FILL if count>0, else IDLE.
REQ-026 count increments on a write alone, decrements on a read alone, and is unchanged when both occur in the same cycle.
REQ-027 Writes continue during BURST; full blocks writes only.
REQ-028 A flush arriving during BURST is registered and takes effect at burst end if words remain.
REQ-029 Pointers wrap from DEPTH-1 to 0 with no loss or duplication.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, wptr=rptr=0, count=0, burst_rem=0, pending flush cleared; mem_wen=mem_ren=out_valid=burst_done=0; in_ready=1, empty=1, full=0.
REQ-031 Reset mid-burst discards all stored words and the in-flight read; out_valid=0 in the cycle after the reset edge; memory contents are not cleared.

Structure
REQ-032 Shared package mem_xfer_pkg holds the FSM state enum and the default DATA_WIDTH, DEPTH and BURST_LEN constants.
REQ-033 One natural sub-module: xfer_ptr_cnt (wptr/rptr/count with wrap and full/empty); the FSM lives in mem_xfer_ctrl.

Verification
REQ-034 Write 16 words 0x1..0x10 one per 4 cycles with out_ready=1 -> BURST starts; 16 consecutive out_valid words 0x1..0x10; burst_done on 0x10; ends in IDLE.
REQ-035 Write 5 words, then pulse flush -> 5-word burst, burst_done on word 5, count=0.
REQ-036 out_ready=0, write 64 words -> full=1, in_ready=0; a 65th in_valid is not written; then out_ready=1 -> four 16-word bursts, in order.
REQ-037 Continuous writes across pointer wrap (more than 100 words total) with out_ready toggling every 3 cycles -> output sequence equals input sequence; count matches the scoreboard every cycle.
REQ-038 Simultaneous write and read at count=20 -> count stays 20.
REQ-039 rst asserted mid-burst after 7 words -> next cycle out_valid=0, count=0, empty=1, state=IDLE; a new 16-word fill bursts correctly starting at address 0.
